// File: rtl/cpu2.sv
// cpu2 -- single-cycle 32-bit MIPS-subset processor core.
//
// One instruction is fetched, decoded and executed every Clk period. The
// instruction memory is combinational (Inst is the word at Iaddr); the data
// memory reads combinationally (Dread is the word at Daddr) and writes on the
// rising Clk edge when Wmem is high. PC, register file and data-memory write
// all commit on the same rising edge.
//
// Ports:
//   Clk    in   1   system clock, state updates on the rising edge
//   Clrn   in   1   asynchronous active-low reset (PC and all registers -> 0)
//   Inst   in  32   instruction word at Iaddr
//   Dread  in  32   data word at Daddr
//   Iaddr  out 32   byte address of the current instruction (PC)
//   Daddr  out 32   byte address for data access (ALU result)
//   Dwrite out 32   store data (register rt)
//   Wmem   out  1   data-memory write enable, high only for sw
//
// Supported: add sub and or xor sll srl sra jr, addi andi ori xori lw sw
// beq bne lui, j, and jal when built with CPU2_JAL_EN defined.
//
// Configuration macro:
//   CPU2_JAL_EN  defined   -> jal links PC+4 into $31 and jumps
//                undefined -> opcode 6'b000011 is a NOP; no link write path
//
// Anything not decoded is a NOP: no register write, Wmem = 0, PC+4.

module cpu2 (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [31:0] Inst,
  input  logic [31:0] Dread,
  output logic [31:0] Iaddr,
  output logic [31:0] Daddr,
  output logic [31:0] Dwrite,
  output logic        Wmem
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
  } alu_op_e;

  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_HIGH} ext_e;
  typedef enum logic [1:0] {DST_RD, DST_RT, DST_LINK} dst_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_e;
  typedef enum logic [2:0] {NPC_SEQ, NPC_BEQ, NPC_BNE, NPC_JUMP, NPC_JR} npc_e;

  // Immediate extension helpers
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

  // Architectural state
  logic [31:0] pc_r;
  logic [31:0] regs_r [0:31];

  // Instruction fields
  logic [5:0]  op_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [4:0]  sa_s;
  logic [5:0]  funct_s;
  logic [15:0] imm_s;
  logic [25:0] target_s;

  assign op_s     = Inst[31:26];
  assign rs_s     = Inst[25:21];
  assign rt_s     = Inst[20:16];
  assign rd_s     = Inst[15:11];
  assign sa_s     = Inst[10:6];
  assign funct_s  = Inst[5:0];
  assign imm_s    = Inst[15:0];
  assign target_s = Inst[25:0];

  // Decoded control
  alu_op_e     alu_op_s;
  ext_e        ext_s;
  logic        b_imm_s;
  dst_e        dst_s;
  wb_e         wb_s;
  logic        reg_wen_s;
  logic        mem_wr_s;
  npc_e        npc_sel_s;

  // Datapath
  logic [31:0] rs_val_s;
  logic [31:0] rt_val_s;
  logic [31:0] sext_imm_s;
  logic [31:0] ext_imm_s;
  logic [31:0] alu_b_s;
  logic [31:0] alu_s;
  logic [4:0]  wr_addr_s;
  logic [31:0] wr_data_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] br_target_s;
  logic [31:0] jump_target_s;
  logic [31:0] pc_next_s;

  // Main decoder: every unlisted opcode/funct keeps the NOP defaults
  always_comb begin
    alu_op_s  = ALU_ADD;
    ext_s     = EXT_SIGN;
    b_imm_s   = 1'b0;
    dst_s     = DST_RD;
    wb_s      = WB_ALU;
    reg_wen_s = 1'b0;
    mem_wr_s  = 1'b0;
    npc_sel_s = NPC_SEQ;
    case (op_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD: begin reg_wen_s = 1'b1; alu_op_s = ALU_ADD; end
          FN_SUB: begin reg_wen_s = 1'b1; alu_op_s = ALU_SUB; end
          FN_AND: begin reg_wen_s = 1'b1; alu_op_s = ALU_AND; end
          FN_OR:  begin reg_wen_s = 1'b1; alu_op_s = ALU_OR;  end
          FN_XOR: begin reg_wen_s = 1'b1; alu_op_s = ALU_XOR; end
          FN_SLL: begin reg_wen_s = 1'b1; alu_op_s = ALU_SLL; end
          FN_SRL: begin reg_wen_s = 1'b1; alu_op_s = ALU_SRL; end
          FN_SRA: begin reg_wen_s = 1'b1; alu_op_s = ALU_SRA; end
          FN_JR:  begin npc_sel_s = NPC_JR; end
          default: begin reg_wen_s = 1'b0; end
        endcase
      end
      OP_ADDI: begin
        reg_wen_s = 1'b1; dst_s = DST_RT; b_imm_s = 1'b1;
        ext_s = EXT_SIGN; alu_op_s = ALU_ADD;
      end
      OP_ANDI: begin
        reg_wen_s = 1'b1; dst_s = DST_RT; b_imm_s = 1'b1;
        ext_s = EXT_ZERO; alu_op_s = ALU_AND;
      end
      OP_ORI: begin
        reg_wen_s = 1'b1; dst_s = DST_RT; b_imm_s = 1'b1;
        ext_s = EXT_ZERO; alu_op_s = ALU_OR;
      end
      OP_XORI: begin
        reg_wen_s = 1'b1; dst_s = DST_RT; b_imm_s = 1'b1;
        ext_s = EXT_ZERO; alu_op_s = ALU_XOR;
      end
      OP_LUI: begin
        reg_wen_s = 1'b1; dst_s = DST_RT; b_imm_s = 1'b1;
        ext_s = EXT_HIGH; alu_op_s = ALU_PASSB;
      end
      OP_LW: begin
        reg_wen_s = 1'b1; dst_s = DST_RT; wb_s = WB_MEM;
        b_imm_s = 1'b1; ext_s = EXT_SIGN; alu_op_s = ALU_ADD;
      end
      OP_SW: begin
        mem_wr_s = 1'b1; b_imm_s = 1'b1;
        ext_s = EXT_SIGN; alu_op_s = ALU_ADD;
      end
      OP_BEQ: begin npc_sel_s = NPC_BEQ; end
      OP_BNE: begin npc_sel_s = NPC_BNE; end
      OP_J:   begin npc_sel_s = NPC_JUMP; end
`ifdef CPU2_JAL_EN
      OP_JAL: begin
        npc_sel_s = NPC_JUMP; reg_wen_s = 1'b1;
        dst_s = DST_LINK; wb_s = WB_LINK;
      end
`endif
      default: begin reg_wen_s = 1'b0; end
    endcase
  end

  // Register read ports; $0 is hard-wired to zero on read
  assign rs_val_s = (rs_s == 5'd0) ? 32'h0000_0000 : regs_r[rs_s];
  assign rt_val_s = (rt_s == 5'd0) ? 32'h0000_0000 : regs_r[rt_s];

  assign sext_imm_s = sext16(imm_s);

  // Immediate extension selected by the decoder
  always_comb begin
    ext_imm_s = sext_imm_s;
    case (ext_s)
      EXT_SIGN: ext_imm_s = sext_imm_s;
      EXT_ZERO: ext_imm_s = zext16(imm_s);
      EXT_HIGH: ext_imm_s = {imm_s, 16'h0000};
      default:  ext_imm_s = sext_imm_s;
    endcase
  end

  assign alu_b_s = b_imm_s ? ext_imm_s : rt_val_s;

  // ALU; shifts take rt and the sa field, add/sub wrap without trapping
  always_comb begin
    alu_s = 32'h0000_0000;
    case (alu_op_s)
      ALU_ADD:   alu_s = rs_val_s + alu_b_s;
      ALU_SUB:   alu_s = rs_val_s - alu_b_s;
      ALU_AND:   alu_s = rs_val_s & alu_b_s;
      ALU_OR:    alu_s = rs_val_s | alu_b_s;
      ALU_XOR:   alu_s = rs_val_s ^ alu_b_s;
      ALU_SLL:   alu_s = rt_val_s << sa_s;
      ALU_SRL:   alu_s = rt_val_s >> sa_s;
      ALU_SRA:   alu_s = $unsigned($signed(rt_val_s) >>> sa_s);
      ALU_PASSB: alu_s = alu_b_s;
      default:   alu_s = 32'h0000_0000;
    endcase
  end

  assign pc_plus4_s    = pc_r + 32'd4;
  assign br_target_s   = pc_plus4_s + {sext_imm_s[29:0], 2'b00};
  assign jump_target_s = {pc_plus4_s[31:28], target_s, 2'b00};

  // Register write-port address and data selection
  always_comb begin
    wr_addr_s = rd_s;
    wr_data_s = alu_s;
    case (dst_s)
      DST_RD:   wr_addr_s = rd_s;
      DST_RT:   wr_addr_s = rt_s;
`ifdef CPU2_JAL_EN
      DST_LINK: wr_addr_s = 5'd31;
`endif
      default:  wr_addr_s = rd_s;
    endcase
    case (wb_s)
      WB_ALU:   wr_data_s = alu_s;
      WB_MEM:   wr_data_s = Dread;
`ifdef CPU2_JAL_EN
      WB_LINK:  wr_data_s = pc_plus4_s;
`endif
      default:  wr_data_s = alu_s;
    endcase
  end

  // Next-PC selection
  always_comb begin
    pc_next_s = pc_plus4_s;
    case (npc_sel_s)
      NPC_SEQ:  pc_next_s = pc_plus4_s;
      NPC_BEQ:  pc_next_s = (rs_val_s == rt_val_s) ? br_target_s : pc_plus4_s;
      NPC_BNE:  pc_next_s = (rs_val_s != rt_val_s) ? br_target_s : pc_plus4_s;
      NPC_JUMP: pc_next_s = jump_target_s;
      NPC_JR:   pc_next_s = rs_val_s;
      default:  pc_next_s = pc_plus4_s;
    endcase
  end

  // Program counter
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      pc_r <= 32'h0000_0000;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // Register file write port; $0 writes are dropped
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
    end else if (reg_wen_s && (wr_addr_s != 5'd0)) begin
      regs_r[wr_addr_s] <= wr_data_s;
    end
  end

  assign Iaddr  = pc_r;
  assign Daddr  = alu_s;
  assign Dwrite = rt_val_s;
  // Clrn gating keeps an in-flight sw from writing while reset is held
  assign Wmem   = mem_wr_s & Clrn;

endmodule

// File: tb/tb_cpu2.sv
// Self-checking bench for cpu2. The bench plays instruction memory (drives
// Inst each cycle) and data memory (64-word array, combinational read,
// write on the rising edge). An ISA-level model tracks PC, registers and
// memory; register contents are observed through Dwrite (= rt) using
// "and $0,$0,$r" probe instructions.

module tb_cpu2;

  logic        Clk;
  logic        Clrn;
  logic [31:0] Inst;
  logic [31:0] Dread;
  logic [31:0] Iaddr;
  logic [31:0] Daddr;
  logic [31:0] Dwrite;
  logic        Wmem;

  cpu2 dut (
    .Clk(Clk), .Clrn(Clrn), .Inst(Inst), .Dread(Dread),
    .Iaddr(Iaddr), .Daddr(Daddr), .Dwrite(Dwrite), .Wmem(Wmem)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

`ifdef CPU2_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  // Data memory
  logic [31:0] dmem [0:63];
  logic        mem_clr;
  assign Dread = dmem[Daddr[7:2]];

  always @(posedge Clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
    end else if (Wmem) begin
      dmem[Daddr[7:2]] <= Dwrite;
    end
  end

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_reg [0:31];
  logic [31:0] m_mem [0:63];

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] inst;
    logic        wmem;
    logic        chk_daddr;
    logic [31:0] daddr;
    logic [31:0] dwrite;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t v(input logic [31:0] inst, input logic wmem,
                             input logic chk_daddr, input logic [31:0] daddr,
                             input logic [31:0] dwrite);
    vec_t r;
    r.inst = inst; r.wmem = wmem; r.chk_daddr = chk_daddr;
    r.daddr = daddr; r.dwrite = dwrite;
    return r;
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  // probe: and $0,$0,$r -- no architectural effect, shows $r on Dwrite
  function automatic logic [31:0] probe(input logic [4:0] r);
    return r_type(5'd0, r, 5'd0, 5'd0, 6'h24);
  endfunction

  task automatic check(input string tag, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s %s: got %08h expected %08h", tag, field, act, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
  endtask

  // Executes one instruction at the ISA level
  task automatic model_exec(input logic [31:0] ins);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sa, dst;
    logic [15:0] imm;
    logic [31:0] a, b, si, zi, pc4, nxt, res, addr;
    logic        wr;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sa = ins[10:6];  fn = ins[5:0];   imm = ins[15:0];
    a = m_reg[rs]; b = m_reg[rt];
    si = {{16{imm[15]}}, imm}; zi = {16'd0, imm};
    pc4 = m_pc + 32'd4; nxt = pc4; wr = 1'b0; dst = 5'd0; res = 32'd0;
    addr = a + si;
    case (op)
      6'h00: begin
        dst = rd;
        case (fn)
          6'h20: begin wr = 1'b1; res = a + b; end
          6'h22: begin wr = 1'b1; res = a - b; end
          6'h24: begin wr = 1'b1; res = a & b; end
          6'h25: begin wr = 1'b1; res = a | b; end
          6'h26: begin wr = 1'b1; res = a ^ b; end
          6'h00: begin wr = 1'b1; res = b << sa; end
          6'h02: begin wr = 1'b1; res = b >> sa; end
          6'h03: begin wr = 1'b1; res = $unsigned($signed(b) >>> sa); end
          6'h08: nxt = a;
          default: ;
        endcase
      end
      6'h08: begin wr = 1'b1; dst = rt; res = a + si; end
      6'h0C: begin wr = 1'b1; dst = rt; res = a & zi; end
      6'h0D: begin wr = 1'b1; dst = rt; res = a | zi; end
      6'h0E: begin wr = 1'b1; dst = rt; res = a ^ zi; end
      6'h0F: begin wr = 1'b1; dst = rt; res = {imm, 16'd0}; end
      6'h23: begin wr = 1'b1; dst = rt; res = m_mem[addr[7:2]]; end
      6'h2B: m_mem[addr[7:2]] = b;
      6'h04: if (a == b) nxt = pc4 + (si << 2);
      6'h05: if (a != b) nxt = pc4 + (si << 2);
      6'h02: nxt = {pc4[31:28], ins[25:0], 2'b00};
      6'h03: if (JAL_EN) begin
               nxt = {pc4[31:28], ins[25:0], 2'b00};
               wr = 1'b1; dst = 5'd31; res = pc4;
             end
      default: ;
    endcase
    if (wr && dst != 5'd0) m_reg[dst] = res;
    m_pc = nxt;
  endtask

  // Called just after a falling edge; drives Inst, checks, then commits one cycle
  task automatic apply(input logic [31:0] ins, input logic [31:0] e_iaddr,
                       input logic e_wmem, input logic chk_daddr,
                       input logic [31:0] e_daddr, input logic [31:0] e_dwrite,
                       input string tag);
    Inst = ins;
    #1;
    check(tag, "Iaddr", Iaddr, e_iaddr);
    check(tag, "Wmem", {31'd0, Wmem}, {31'd0, e_wmem});
    check(tag, "Dwrite", Dwrite, e_dwrite);
    if (chk_daddr) check(tag, "Daddr", Daddr, e_daddr);
    model_exec(ins);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Applies one instruction with expectations taken from the model
  task automatic apply_model(input logic [31:0] ins, input string tag);
    logic [5:0] op;
    logic       is_mem;
    op = ins[31:26];
    is_mem = (op == 6'h23) || (op == 6'h2B);
    apply(ins, m_pc, op == 6'h2B, is_mem,
          m_reg[ins[25:21]] + {{16{ins[15]}}, ins[15:0]}, m_reg[ins[20:16]], tag);
  endtask

  task automatic rand_inst(output logic [31:0] ins);
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    int k;
    logic [5:0] fns [0:7];
    logic [5:0] iops [0:4];
    fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03};
    iops = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    rs = 5'($urandom_range(0, 15)); rt = 5'($urandom_range(0, 15));
    rd = 5'($urandom_range(0, 15)); sa = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    k = $urandom_range(0, 19);
    if (k < 8)        ins = r_type(rs, rt, rd, sa, fns[k]);
    else if (k == 8)  ins = r_type(rs, rt, rd, sa, 6'h08);
    else if (k < 14)  ins = i_type(iops[k-9], rs, rt, imm);
    else if (k == 14) ins = i_type(6'h23, rs, rt, imm);
    else if (k == 15) ins = i_type(6'h2B, rs, rt, imm);
    else if (k == 16) ins = i_type(6'h04, rs, rt, imm);
    else if (k == 17) ins = i_type(6'h05, rs, rt, imm);
    else if (k == 18) ins = j_type(($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03, 26'($urandom));
    else              ins = $urandom;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ins;
    Clrn = 1'b1; Inst = 32'd0; mem_clr = 1'b1;
    for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
    #2 Clrn = 1'b0;
    #1;
    // Reset held: PC 0, sw decoded but Wmem forced low, Daddr follows decode
    Inst = i_type(6'h2B, 5'd0, 5'd0, 16'd8);
    #1;
    check("rst", "Iaddr", Iaddr, 32'd0);
    check("rst", "Wmem", {31'd0, Wmem}, 32'd0);
    check("rst", "Daddr", Daddr, 32'd8);
    @(posedge Clk); @(negedge Clk);
    mem_clr = 1'b0;
    for (int r = 0; r < 32; r++) begin
      Inst = probe(5'(r)); #1;
      check($sformatf("rst_reg%0d", r), "Dwrite", Dwrite, 32'd0);
    end
    model_reset();
    @(negedge Clk);
    Clrn = 1'b1;

    // Straight-line ALU / logic / memory program starting at address 0
    tbl.push_back(v(i_type(6'h08, 0, 1, 16'd5),      0, 0, 0, 32'h0));
    tbl.push_back(v(i_type(6'h08, 0, 2, 16'hFFFD),   0, 0, 0, 32'h0));
    tbl.push_back(v(r_type(1, 2, 3, 0, 6'h20),       0, 0, 0, 32'hFFFFFFFD));
    tbl.push_back(v(r_type(1, 2, 4, 0, 6'h22),       0, 0, 0, 32'hFFFFFFFD));
    tbl.push_back(v(r_type(0, 1, 5, 4, 6'h00),       0, 0, 0, 32'h5));
    tbl.push_back(v(r_type(0, 2, 6, 1, 6'h03),       0, 0, 0, 32'hFFFFFFFD));
    tbl.push_back(v(probe(3),                        0, 0, 0, 32'h2));
    tbl.push_back(v(probe(4),                        0, 0, 0, 32'h8));
    tbl.push_back(v(probe(5),                        0, 0, 0, 32'h50));
    tbl.push_back(v(probe(6),                        0, 0, 0, 32'hFFFFFFFE));
    tbl.push_back(v(i_type(6'h0F, 0, 7, 16'h1234),   0, 0, 0, 32'h0));
    tbl.push_back(v(i_type(6'h0D, 7, 7, 16'h5678),   0, 0, 0, 32'h12340000));
    tbl.push_back(v(i_type(6'h0C, 7, 8, 16'hFF00),   0, 0, 0, 32'h0));
    tbl.push_back(v(probe(8),                        0, 0, 0, 32'h5600));
    tbl.push_back(v(i_type(6'h0F, 0, 9, 16'h7FFF),   0, 0, 0, 32'h0));
    tbl.push_back(v(i_type(6'h0D, 9, 9, 16'hFFFF),   0, 0, 0, 32'h7FFF0000));
    tbl.push_back(v(i_type(6'h08, 0, 11, 16'd1),     0, 0, 0, 32'h0));
    tbl.push_back(v(r_type(9, 11, 12, 0, 6'h20),     0, 0, 0, 32'h1));
    tbl.push_back(v(probe(12),                       0, 0, 0, 32'h80000000));
    tbl.push_back(v(i_type(6'h08, 9, 13, 16'd1),     0, 0, 0, 32'h0));
    tbl.push_back(v(probe(13),                       0, 0, 0, 32'h80000000));
    tbl.push_back(v(i_type(6'h2B, 0, 7, 16'd8),      1, 1, 32'd8, 32'h12345678));
    tbl.push_back(v(i_type(6'h23, 0, 10, 16'd8),     0, 1, 32'd8, 32'h0));
    tbl.push_back(v(probe(10),                       0, 0, 0, 32'h12345678));
    tbl.push_back(v(i_type(6'h08, 0, 0, 16'd7),      0, 0, 0, 32'h0));
    tbl.push_back(v(probe(0),                        0, 0, 0, 32'h0));
    tbl.push_back(v(r_type(7, 1, 14, 0, 6'h26),      0, 0, 0, 32'h5));
    tbl.push_back(v(r_type(0, 2, 15, 28, 6'h02),     0, 0, 0, 32'hFFFFFFFD));
    tbl.push_back(v(i_type(6'h0E, 7, 16, 16'hFFFF),  0, 0, 0, 32'h0));
    tbl.push_back(v(r_type(3, 4, 17, 0, 6'h25),      0, 0, 0, 32'h8));
    tbl.push_back(v(probe(14),                       0, 0, 0, 32'h1234567D));
    tbl.push_back(v(probe(15),                       0, 0, 0, 32'hF));
    tbl.push_back(v(probe(16),                       0, 0, 0, 32'h1234A987));
    tbl.push_back(v(probe(17),                       0, 0, 0, 32'hA));
    tbl.push_back(v(i_type(6'h2B, 1, 1, 16'hFFFF),   1, 1, 32'd4, 32'h5));
    tbl.push_back(v(i_type(6'h23, 0, 19, 16'd4),     0, 1, 32'd4, 32'h0));
    tbl.push_back(v(probe(19),                       0, 0, 0, 32'h5));
    tbl.push_back(v(i_type(6'h3F, 1, 2, 16'h1234),   0, 0, 0, 32'hFFFFFFFD));
    tbl.push_back(v(probe(2),                        0, 0, 0, 32'hFFFFFFFD));
    tbl.push_back(v(r_type(1, 2, 3, 0, 6'h3F),       0, 0, 0, 32'hFFFFFFFD));
    tbl.push_back(v(probe(3),                        0, 0, 0, 32'h2));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].inst, 32'(i * 4), tbl[i].wmem, tbl[i].chk_daddr,
            tbl[i].daddr, tbl[i].dwrite, $sformatf("tbl%0d", i));
    end

    // Reset asserted in the middle of a sw cycle
    Inst = i_type(6'h2B, 5'd0, 5'd7, 16'd12);
    #1;
    check("rst_mid", "Wmem_pre", {31'd0, Wmem}, 32'd1);
    check("rst_mid", "Daddr", Daddr, 32'd12);
    check("rst_mid", "Dwrite", Dwrite, 32'h12345678);
    Clrn = 1'b0;
    #1;
    check("rst_mid", "Iaddr", Iaddr, 32'd0);
    check("rst_mid", "Wmem", {31'd0, Wmem}, 32'd0);
    @(posedge Clk); @(negedge Clk);
    check("rst_mid", "mem12", dmem[3], m_mem[3]);
    for (int r = 0; r < 32; r++) begin
      Inst = probe(5'(r)); #1;
      check($sformatf("rst_mid_reg%0d", r), "Dwrite", Dwrite, 32'd0);
    end
    model_reset();
    @(negedge Clk);
    Clrn = 1'b1;

    // Control flow from address 0
    apply(i_type(6'h08, 0, 20, 16'd3), 32'h00, 0, 0, 0, 32'h0, "cf_setup");
    for (int i = 1; i < 8; i++) apply(32'h0, 32'(i * 4), 0, 0, 0, 32'h0, "cf_nop");
    apply(i_type(6'h04, 0, 0, 16'd2),      32'h20, 0, 0, 0, 32'h0, "cf_beq");
    apply(i_type(6'h05, 0, 0, 16'd5),      32'h2C, 0, 0, 0, 32'h0, "cf_bne_nt");
    apply(i_type(6'h05, 20, 0, 16'hFFFE),  32'h30, 0, 0, 0, 32'h0, "cf_bne_back");
    apply(j_type(6'h02, 26'h10),           32'h2C, 0, 0, 0, 32'h0, "cf_j");
    apply(j_type(6'h03, 26'h30),           32'h40, 0, 0, 0, 32'h0, "cf_jal");
    apply(probe(31), JAL_EN ? 32'hC0 : 32'h44, 0, 0, 0,
          JAL_EN ? 32'h44 : 32'h0, "cf_link");
    apply(r_type(31, 0, 0, 0, 6'h08), JAL_EN ? 32'hC4 : 32'h48, 0, 0, 0, 32'h0, "cf_jr");
    apply(i_type(6'h04, 20, 0, 16'd5), JAL_EN ? 32'h44 : 32'h0, 0, 0, 0, 32'h0, "cf_beq_nt");
    apply(32'h0, JAL_EN ? 32'h48 : 32'h4, 0, 0, 0, 32'h0, "cf_after");

    // Randomized instruction stream against the model
    for (int i = 0; i < 400; i++) begin
      rand_inst(ins);
      apply_model(ins, $sformatf("rand%0d", i));
    end
    for (int r = 0; r < 32; r++) apply_model(probe(5'(r)), $sformatf("final_reg%0d", r));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
